// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with the start/done
// handshake shared with the Booth multiplier; divide-by-zero and overflow never trap.
package core_config_pkg;
    localparam int XLEN = 32;
endpackage

module divider
    import core_config_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            signed_op,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            busy,
    output logic            done
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_COMPUTE,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state;

    // Handshake: start is honoured only in S_IDLE; done pulses for one cycle with
    // quotient/remainder valid, and busy covers every cycle the FSM is not idle.

    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic            sgn;
    logic [XLEN-1:0] abs_dvs;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] res_r;

    logic            dvd_neg;
    logic            dvs_neg;
    logic [XLEN-1:0] abs_dvd_c;
    logic [XLEN-1:0] abs_dvs_c;
    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   t;
    logic [XLEN-1:0] q_next;
    logic [XLEN-1:0] r_next;

    always_comb begin
        dvd_neg   = sgn & dvd[XLEN-1];
        dvs_neg   = sgn & dvs[XLEN-1];
        abs_dvd_c = dvd_neg ? -dvd : dvd;
        abs_dvs_c = dvs_neg ? -dvs : dvs;
        // The partial remainder is always below the divisor, so XLEN bits hold it
        // between iterations; only the shifted trial value needs the extra bit.
        r_sh      = {r, q[XLEN-1]};
        t         = r_sh - {1'b0, abs_dvs};
        q_next    = {q[XLEN-2:0], ~t[XLEN]};
        r_next    = t[XLEN] ? r_sh[XLEN-1:0] : t[XLEN-1:0];
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dvd       <= '0;
            dvs       <= '0;
            sgn       <= 1'b0;
            abs_dvs   <= '0;
            r         <= '0;
            q         <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            res_q     <= '0;
            res_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        sgn   <= signed_op;
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    neg_q   <= dvd_neg ^ dvs_neg;
                    neg_r   <= dvd_neg;
                    abs_dvs <= abs_dvs_c;
                    r       <= '0;
                    q       <= abs_dvd_c;
                    cnt     <= '0;
                    if (dvs == '0) begin
                        res_q <= ALL_ONES;
                        res_r <= dvd;
                        state <= S_DONE;
                    end else if (sgn && (dvd == INT_MIN) && (dvs == ALL_ONES)) begin
                        res_q <= dvd;
                        res_r <= '0;
                        state <= S_DONE;
                    end else begin
                        state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    res_q <= neg_q ? -q : q;
                    res_r <= neg_r ? -r : r;
                    state <= S_DONE;
                end
                S_DONE: begin
                    quotient  <= res_q;
                    remainder <= res_r;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: the driver queues expected results per operation and
// an independent monitor checks values, latency and busy length on every done pulse.
module tb_divider;

    localparam int XLEN = 32;
    localparam int W = 2*XLEN + 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            signed_op;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            busy;
    logic            done;

    divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .signed_op (signed_op),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    int           start_q[$];
    int           total = 0;
    int           bad = 0;
    int           done_seen = 0;
    int           exp_done = 0;
    int           busy_cnt = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           sc;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual q=%h r=%h required no done",
                             quotient, remainder);
                end else begin
                    e  = exp_q.pop_front();
                    sc = start_q.pop_front();
                    check("quotient", quotient, e[W-1 -: XLEN]);
                    check("remainder", remainder, e[XLEN+7 -: XLEN]);
                    check("latency", XLEN'(cyc - sc), XLEN'(e[7:0]));
                    check("busy_cycles", XLEN'(busy_cnt), XLEN'(e[7:0]));
                end
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge: the following posedge is the accepting edge.
    task automatic put(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s,
                       input logic [XLEN-1:0] eq, input logic [XLEN-1:0] er, input int lat);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        exp_q.push_back({eq, er, 8'(lat)});
        start_q.push_back(cyc + 1);
        exp_done++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_seen >= exp_done) break;
        end
        check("done_count", XLEN'(done_seen), XLEN'(exp_done));
    endtask

    task automatic run(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s,
                       input logic [XLEN-1:0] eq, input logic [XLEN-1:0] er, input int lat);
        @(negedge clk);
        put(a, b, s, eq, er, lat);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        check("rst_busy", XLEN'(busy), '0);
        check("rst_done", XLEN'(done), '0);
        rst_n = 1'b1;

        run(32'd100,       32'd7,        1'b0, 32'd14,        32'd2,        35);
        run(32'hFFFFFFF9,  32'd2,        1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF, 35);
        run(32'd7,         32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD,  32'd1,        35);
        run(32'hFFFFFF9C,  32'hFFFFFFF9, 1'b1, 32'd14,        32'hFFFFFFFE, 35);
        run(32'h12345678,  32'd0,        1'b1, 32'hFFFFFFFF,  32'h12345678, 2);
        run(32'h12345678,  32'd0,        1'b0, 32'hFFFFFFFF,  32'h12345678, 2);
        run(32'hFFFFFFFB,  32'd0,        1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB, 2);
        run(32'h80000000,  32'hFFFFFFFF, 1'b1, 32'h80000000,  32'd0,        2);
        run(32'h80000000,  32'hFFFFFFFF, 1'b0, 32'd0,         32'h80000000, 35);
        run(32'hFFFFFFFF,  32'h80000000, 1'b0, 32'd1,         32'h7FFFFFFF, 35);
        run(32'h80000000,  32'd1,        1'b1, 32'h80000000,  32'd0,        35);
        run(32'h80000000,  32'd2,        1'b1, 32'hC0000000,  32'd0,        35);
        run(32'hFFFFFFFF,  32'd1,        1'b0, 32'hFFFFFFFF,  32'd0,        35);
        run(32'd5,         32'd9,        1'b0, 32'd0,         32'd5,        35);

        // A start pulse while busy must be ignored.
        @(negedge clk);
        put(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 35);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        dividend  = 32'd55;
        divisor   = 32'd5;
        signed_op = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Start asserted in the done cycle is accepted.
        @(negedge clk);
        put(32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 35);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        put(32'd50, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFF0, 32'd2, 35);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Operand inputs change mid-computation without effect.
        @(negedge clk);
        put(32'd1000000, 32'd1000, 1'b0, 32'd1000, 32'd0, 35);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        dividend  = 32'hFFFFFFFF;
        divisor   = 32'd1;
        signed_op = 1'b1;
        wait_done();

        // Reset during COMPUTE abandons the operation silently.
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        signed_op = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", XLEN'(busy), '0);
        check("mid_rst_done", XLEN'(done), '0);
        check("mid_rst_quotient", quotient, '0);
        check("mid_rst_remainder", remainder, '0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_idle", XLEN'(busy), '0);
        run(32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 35);

        repeat (3) @(negedge clk);
        check("queue_empty", XLEN'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
